// File: rtl/train_seq_pkg.sv
// Shared constants for the train step sequencer: state encodings,
// default parameter values and a counter-width helper.
package train_seq_pkg;

    localparam int unsigned STEP_W_DEF    = 4;
    localparam int unsigned HOLD_STEP_DEF = 6;
    localparam int unsigned LAST_STEP_DEF = 14;
    localparam int unsigned DWELL_DEF     = 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_FINAL = 2'd3;

    // Counter width able to hold 0..dwell-1 (at least one bit).
    function automatic int unsigned dwell_cnt_w(input int unsigned dwell);
        return (dwell <= 1) ? 1 : $clog2(dwell);
    endfunction

endpackage

// File: rtl/train_dwell_timer.sv
// Dwell timer: counts consecutive inc cycles and fires on the DWELL-th one.
// fire is combinational so the step event lands on the qualifying cycle.
module train_dwell_timer
    import train_seq_pkg::*;
#(
    parameter int unsigned DWELL = DWELL_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic fire
);

    localparam int unsigned CW = dwell_cnt_w(DWELL);
    localparam logic [CW-1:0] TERM = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, a fire restarts the count, otherwise increment.
    always_comb begin
        fire  = inc && (cnt_q == TERM);
        cnt_d = cnt_q;
        if (clear || fire) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/train_step_seq.sv
// Train step sequencer: IDLE -> RUN stepping -> HOLD park -> RUN -> FINAL.
// All outputs are registered; abort returns to IDLE from any state.
module train_step_seq
    import train_seq_pkg::*;
#(
    parameter int unsigned STEP_W    = STEP_W_DEF,
    parameter int unsigned HOLD_STEP = HOLD_STEP_DEF,
    parameter int unsigned LAST_STEP = LAST_STEP_DEF,
    parameter int unsigned DWELL     = DWELL_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              abort,
    output logic [STEP_W-1:0] step_o,
    output logic [1:0]        state_o,
    output logic              hold_phase,
    output logic              start_pulse,
    output logic              done_pulse,
    output logic              busy
);

    if (!(HOLD_STEP > 1 && HOLD_STEP + 3 <= LAST_STEP &&
          (LAST_STEP >> STEP_W) == 0 && DWELL >= 1)) begin : g_bad_params
        $error("train_step_seq: illegal STEP_W/HOLD_STEP/LAST_STEP/DWELL combination");
    end

    localparam logic [STEP_W-1:0] HOLD_L = STEP_W'(HOLD_STEP);
    localparam logic [STEP_W-1:0] LAST_L = STEP_W'(LAST_STEP);

    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              hold_phase_q, hold_phase_d;
    logic              start_pulse_q, start_pulse_d;
    logic              done_pulse_q, done_pulse_d;
    logic              busy_q, busy_d;

    logic              dwell_clear;
    logic              dwell_inc;
    logic              dwell_fire;
    logic [STEP_W-1:0] step_inc;
    logic [STEP_W-1:0] step_resume;

    // Dwell counting only runs in RUN while advance stays high.
    always_comb begin
        dwell_inc   = (state_q == ST_RUN) && advance && !abort;
        dwell_clear = abort || !advance || (state_q != ST_RUN);
    end

    train_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (dwell_clear),
        .inc   (dwell_inc),
        .fire  (dwell_fire)
    );

    // Next-state, step and pulse computation; abort overrides state rules.
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        hold_phase_d  = hold_phase_q;
        start_pulse_d = 1'b0;
        done_pulse_d  = 1'b0;
        step_inc      = step_q + STEP_W'(1);
        step_resume   = HOLD_L + STEP_W'(2) + STEP_W'(hold_phase_q);
        if (abort) begin
            state_d      = ST_IDLE;
            step_d       = '0;
            hold_phase_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (advance) begin
                        state_d       = ST_RUN;
                        step_d        = STEP_W'(1);
                        start_pulse_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (dwell_fire) begin
                        if (step_inc == HOLD_L) begin
                            state_d      = ST_HOLD;
                            step_d       = HOLD_L;
                            hold_phase_d = 1'b0;
                        end else if (step_inc >= LAST_L) begin
                            state_d = ST_FINAL;
                            step_d  = LAST_L;
                        end else begin
                            step_d = step_inc;
                        end
                    end
                end
                ST_HOLD: begin
                    if (advance) begin
                        hold_phase_d = 1'b0;
                        if (step_resume >= LAST_L) begin
                            state_d = ST_FINAL;
                            step_d  = LAST_L;
                        end else begin
                            state_d = ST_RUN;
                            step_d  = step_resume;
                        end
                    end else begin
                        hold_phase_d = !hold_phase_q;
                    end
                end
                default: begin
                    if (!advance) begin
                        state_d      = ST_IDLE;
                        step_d       = '0;
                        done_pulse_d = 1'b1;
                    end
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Output and state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            step_q        <= '0;
            hold_phase_q  <= 1'b0;
            start_pulse_q <= 1'b0;
            done_pulse_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            hold_phase_q  <= hold_phase_d;
            start_pulse_q <= start_pulse_d;
            done_pulse_q  <= done_pulse_d;
            busy_q        <= busy_d;
        end
    end

    assign step_o      = step_q;
    assign state_o     = state_q;
    assign hold_phase  = hold_phase_q;
    assign start_pulse = start_pulse_q;
    assign done_pulse  = done_pulse_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_train_step_seq.sv
// Bench for train_step_seq: default config driven from a vector table,
// plus hand sequences for DWELL=3 and a 5-bit wide traversal.
module tb_train_step_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: default parameters.
    logic       rst_n0, adv0, ab0;
    logic [3:0] step0;
    logic [1:0] st0;
    logic       ph0, sp0, dp0, bz0;

    // Instance 1: DWELL=3.
    logic       rst_n1, adv1, ab1;
    logic [3:0] step1;
    logic [1:0] st1;
    logic       ph1, sp1, dp1, bz1;

    // Instance 2: STEP_W=5, HOLD_STEP=20, LAST_STEP=31.
    logic       rst_n2, adv2, ab2;
    logic [4:0] step2;
    logic [1:0] st2;
    logic       ph2, sp2, dp2, bz2;

    train_step_seq u_dut0 (
        .clk(clk), .rst_n(rst_n0), .advance(adv0), .abort(ab0),
        .step_o(step0), .state_o(st0), .hold_phase(ph0),
        .start_pulse(sp0), .done_pulse(dp0), .busy(bz0)
    );

    train_step_seq #(.DWELL(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .advance(adv1), .abort(ab1),
        .step_o(step1), .state_o(st1), .hold_phase(ph1),
        .start_pulse(sp1), .done_pulse(dp1), .busy(bz1)
    );

    train_step_seq #(.STEP_W(5), .HOLD_STEP(20), .LAST_STEP(31)) u_dut2 (
        .clk(clk), .rst_n(rst_n2), .advance(adv2), .abort(ab2),
        .step_o(step2), .state_o(st2), .hold_phase(ph2),
        .start_pulse(sp2), .done_pulse(dp2), .busy(bz2)
    );

    typedef struct {
        logic       rst_n;
        logic       adv;
        logic       ab;
        int         step;
        int         st;
        int         ph;
        int         sp;
        int         dp;
        int         bz;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic a, input logic b,
                       input int step, input int st, input int ph,
                       input int sp, input int dp, input int bz);
        vec_t v;
        v.rst_n = r; v.adv = a; v.ab = b;
        v.step = step; v.st = st; v.ph = ph; v.sp = sp; v.dp = dp; v.bz = bz;
        vecs.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input int step, input int st,
                        input int sp, input int dp, input int bz);
        chk({tag, ".step"}, int'(step1), step);
        chk({tag, ".state"}, int'(st1), st);
        chk({tag, ".start"}, int'(sp1), sp);
        chk({tag, ".done"}, int'(dp1), dp);
        chk({tag, ".busy"}, int'(bz1), bz);
    endtask

    initial begin
        rst_n0 = 1'b0; adv0 = 1'b0; ab0 = 1'b0;
        rst_n1 = 1'b0; adv1 = 1'b0; ab1 = 1'b0;
        rst_n2 = 1'b0; adv2 = 1'b0; ab2 = 1'b0;

        // --- table for the default instance ---
        //   rst adv ab  step st ph sp dp bz
        add(0, 0, 0,  0, 0, 0, 0, 0, 0);   // reset
        add(1, 1, 0,  1, 1, 0, 1, 0, 1);   // start
        add(1, 1, 0,  2, 1, 0, 0, 0, 1);
        add(1, 1, 0,  3, 1, 0, 0, 0, 1);
        add(1, 1, 0,  4, 1, 0, 0, 0, 1);
        add(1, 1, 0,  5, 1, 0, 0, 0, 1);
        add(1, 1, 0,  6, 2, 0, 0, 0, 1);   // park in HOLD
        add(1, 1, 0,  8, 1, 0, 0, 0, 1);   // release phase 0 -> 8
        add(1, 1, 0,  9, 1, 0, 0, 0, 1);
        add(1, 1, 0, 10, 1, 0, 0, 0, 1);
        add(1, 1, 0, 11, 1, 0, 0, 0, 1);
        add(1, 1, 0, 12, 1, 0, 0, 0, 1);
        add(1, 1, 0, 13, 1, 0, 0, 0, 1);
        add(1, 1, 0, 14, 3, 0, 0, 0, 1);   // FINAL
        add(1, 1, 0, 14, 3, 0, 0, 0, 1);   // held in FINAL
        add(1, 0, 0,  0, 0, 0, 0, 1, 0);   // done pulse
        add(1, 0, 0,  0, 0, 0, 0, 0, 0);   // pulse lasts one cycle
        add(1, 1, 0,  1, 1, 0, 1, 0, 1);
        add(1, 1, 0,  2, 1, 0, 0, 0, 1);
        add(1, 1, 0,  3, 1, 0, 0, 0, 1);
        add(1, 1, 0,  4, 1, 0, 0, 0, 1);
        add(1, 1, 0,  5, 1, 0, 0, 0, 1);
        add(1, 1, 0,  6, 2, 0, 0, 0, 1);
        add(1, 0, 0,  6, 2, 1, 0, 0, 1);   // phase toggles 1,0,1
        add(1, 0, 0,  6, 2, 0, 0, 0, 1);
        add(1, 0, 0,  6, 2, 1, 0, 0, 1);
        add(1, 1, 0,  9, 1, 0, 0, 0, 1);   // release phase 1 -> 9
        add(1, 1, 0, 10, 1, 0, 0, 0, 1);
        add(1, 1, 1,  0, 0, 0, 0, 0, 0);   // abort beats advance
        add(1, 0, 0,  0, 0, 0, 0, 0, 0);
        add(1, 1, 0,  1, 1, 0, 1, 0, 1);
        add(1, 1, 0,  2, 1, 0, 0, 0, 1);
        add(1, 1, 0,  3, 1, 0, 0, 0, 1);
        add(1, 1, 0,  4, 1, 0, 0, 0, 1);
        add(1, 1, 0,  5, 1, 0, 0, 0, 1);
        add(1, 1, 0,  6, 2, 0, 0, 0, 1);
        add(1, 0, 0,  6, 2, 1, 0, 0, 1);
        add(0, 0, 0,  0, 0, 0, 0, 0, 0);   // reset in HOLD phase 1
        add(1, 0, 0,  0, 0, 0, 0, 0, 0);   // no pulse on release
        add(1, 1, 0,  1, 1, 0, 1, 0, 1);
        add(1, 1, 0,  2, 1, 0, 0, 0, 1);
        add(1, 1, 1,  0, 0, 0, 0, 0, 0);   // abort from RUN
        add(1, 1, 0,  1, 1, 0, 1, 0, 1);
        add(0, 1, 0,  0, 0, 0, 0, 0, 0);   // reset beats advance
        add(1, 0, 0,  0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst_n0 = vecs[i].rst_n;
            adv0   = vecs[i].adv;
            ab0    = vecs[i].ab;
            tick();
            chk($sformatf("v%0d.step", i),  int'(step0), vecs[i].step);
            chk($sformatf("v%0d.state", i), int'(st0),   vecs[i].st);
            chk($sformatf("v%0d.phase", i), int'(ph0),   vecs[i].ph);
            chk($sformatf("v%0d.start", i), int'(sp0),   vecs[i].sp);
            chk($sformatf("v%0d.done", i),  int'(dp0),   vecs[i].dp);
            chk($sformatf("v%0d.busy", i),  int'(bz0),   vecs[i].bz);
        end

        // --- DWELL=3: high 2, low 1, high 3 -> one step after third high ---
        rst_n1 = 1'b0; adv1 = 1'b0;
        tick();
        chk1("dw.rst", 0, 0, 0, 0, 0);
        rst_n1 = 1'b1; adv1 = 1'b1;
        tick();
        chk1("dw.start", 1, 1, 1, 0, 1);
        adv1 = 1'b1; tick(); chk1("dw.h1", 1, 1, 0, 0, 1);
        adv1 = 1'b1; tick(); chk1("dw.h2", 1, 1, 0, 0, 1);
        adv1 = 1'b0; tick(); chk1("dw.l1", 1, 1, 0, 0, 1);
        adv1 = 1'b1; tick(); chk1("dw.h3a", 1, 1, 0, 0, 1);
        adv1 = 1'b1; tick(); chk1("dw.h3b", 1, 1, 0, 0, 1);
        adv1 = 1'b1; tick(); chk1("dw.h3c", 2, 1, 0, 0, 1);
        adv1 = 1'b0; tick(); chk1("dw.after", 2, 1, 0, 0, 1);

        // --- wide config: full traversal to 31 without wrap ---
        rst_n2 = 1'b0; adv2 = 1'b0;
        tick();
        chk("wide.rst.step", int'(step2), 0);
        chk("wide.rst.busy", int'(bz2), 0);
        rst_n2 = 1'b1; adv2 = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            int es;
            int et;
            tick();
            if (i <= 19)      begin es = i;      et = 1; end
            else if (i == 20) begin es = 20;     et = 2; end
            else if (i <= 29) begin es = i + 1;  et = 1; end
            else              begin es = 31;     et = 3; end
            chk($sformatf("wide.c%0d.step", i),  int'(step2), es);
            chk($sformatf("wide.c%0d.state", i), int'(st2),   et);
        end
        adv2 = 1'b0;
        tick();
        chk("wide.end.step", int'(step2), 0);
        chk("wide.end.state", int'(st2), 0);
        chk("wide.end.done", int'(dp2), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/train_step_seq.md
TRAIN_STEP_SEQ -- requirements
Module: train_step_seq

Interface
REQ-001 SHALL have parameter STEP_W, default 4, width of the step index.
REQ-002 SHALL have parameter HOLD_STEP, default 6, the step at which the sequence parks in the hold pair.
REQ-003 SHALL have parameter LAST_STEP, default 14, the terminal step.
REQ-004 SHALL have parameter DWELL, default 1, the number of consecutive advance-high cycles needed per step in RUN.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port advance, input, 1 bit: step request / hold release.
REQ-008 SHALL have port abort, input, 1 bit: return to IDLE.
REQ-009 SHALL have port step_o, output, STEP_W bits: current step index.
REQ-010 SHALL have port state_o, output, 2 bits: FSM state (IDLE=0, RUN=1, HOLD=2, FINAL=3).
REQ-011 SHALL have port hold_phase, output, 1 bit: alternating phase while in HOLD.
REQ-012 SHALL have port start_pulse, output, 1 bit: one-cycle pulse on sequence start.
REQ-013 SHALL have port done_pulse, output, 1 bit: one-cycle pulse on sequence completion.
REQ-014 SHALL have port busy, output, 1 bit: high whenever state_o != IDLE.

Function
REQ-015 All outputs SHALL be registered; no combinational path from input to output.
REQ-016 Priority SHALL be: rst_n low, then abort, then the state rules below.
REQ-017 In IDLE, advance=1 SHALL give next state RUN, step_o=1 and start_pulse=1 for exactly that cycle; DWELL does not apply.
REQ-018 In RUN, dwell_cnt SHALL count consecutive advance-high cycles; advance=0 clears it; a step event fires on the cycle advance=1 with dwell_cnt==DWELL-1, then dwell_cnt clears.
REQ-019 On a RUN step event, if step_o+1==HOLD_STEP the FSM SHALL enter HOLD with step_o=HOLD_STEP and hold_phase=0.
REQ-020 On a RUN step event, if step_o+1>=LAST_STEP the FSM SHALL enter FINAL with step_o=LAST_STEP; otherwise step_o increments by one.
REQ-021 In HOLD with advance=0, hold_phase SHALL toggle every cycle and step_o SHALL hold.
REQ-022 In HOLD with advance=1, step_o SHALL become HOLD_STEP+2+hold_phase, hold_phase SHALL clear, and the FSM SHALL enter RUN, or FINAL with step_o=LAST_STEP if that value >=LAST_STEP.
REQ-023 In FINAL, advance=1 SHALL hold the state; advance=0 SHALL give IDLE, step_o=0 and done_pulse=1 for one cycle.
REQ-024 abort=1 SHALL force IDLE, step_o=0, hold_phase=0 and dwell_cnt=0 next cycle from any state, with no start_pulse or done_pulse, even if advance=1 in the same cycle.
REQ-025 Step arithmetic SHALL be STEP_W-bit unsigned; step_o never exceeds LAST_STEP and never wraps.
REQ-026 Elaboration SHALL fail unless 1 < HOLD_STEP, HOLD_STEP+3 <= LAST_STEP < 2**STEP_W, and DWELL >= 1.

Reset
REQ-027 With rst_n=0 at a rising clk edge, the block SHALL set state IDLE, step_o=0, hold_phase=0, start_pulse=0, done_pulse=0, busy=0 and dwell_cnt=0.
REQ-028 Reset asserted mid-sequence, in any state, SHALL behave identically to REQ-027, with no pulse emitted on the cycle reset releases.

Structure
REQ-029 State encodings and default parameter constants SHALL live in shared package train_seq_pkg.
REQ-030 The dwell counter SHALL be sub-module train_dwell_timer, with inputs clk, rst_n, clear and inc, parameter DWELL, and output fire.

Verification (defaults unless stated)
REQ-031 The bench SHALL cover: advance held high from IDLE -> step_o 1..6 then HOLD at 6; one more cycle -> step_o 8; continues to 14 and holds FINAL; advance=0 -> IDLE plus one done_pulse.
REQ-032 The bench SHALL cover: in HOLD, advance=0 for 3 cycles (hold_phase 1,0,1) then advance=1 -> step_o=9, state_o RUN.
REQ-033 The bench SHALL cover: DWELL=3 with advance toggling high 2 cycles, low 1 cycle, high 3 cycles -> exactly one step increment, after the third consecutive high.
REQ-034 The bench SHALL cover: abort=1 together with advance=1 at step 10 -> next cycle step_o=0, IDLE, no pulses.
REQ-035 The bench SHALL cover: rst_n=0 in HOLD with hold_phase=1 -> next edge gives all outputs at reset values; advance=1 after release -> start_pulse and step_o=1.
REQ-036 The bench SHALL cover: STEP_W=5, HOLD_STEP=20, LAST_STEP=31 -> full traversal reaches 31 without wrap.
